// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx; optional flush port under `UART_TXQ_FLUSH_EN.
// Latency: first word launches (uart_tx_en) one cycle after the push edge is visible.
// Backpressure: in_ready drops while full, in reset, or while flushing.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PAYLOAD_BITS-1:0]   in_data,
  output logic                      uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]   uart_tx_data,
  input  logic                      uart_tx_busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      empty,
  output logic                      full
`ifdef UART_TXQ_FLUSH_EN
  ,
  input  logic                      flush
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [LW-1:0]           r_level;
  logic                    r_tx_en;
  logic [PAYLOAD_BITS-1:0] r_tx_data;
  state_t                  r_state;
  state_t                  w_state_nxt;

  logic w_flush;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_launch;

`ifdef UART_TXQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full   = (r_level == FULL_LVL);
  assign w_empty  = (r_level == '0);
  assign in_ready = !w_full && !reset && !w_flush;
  assign w_push   = in_valid && in_ready;

  // A launch coinciding with a flush is suppressed: the flush owns the queue that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !uart_tx_busy && !w_flush) begin
          w_launch    = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (uart_tx_busy) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!uart_tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_tx_en <= w_launch;
      if (w_launch) begin
        r_tx_data <= r_mem[r_rptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_launch) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_launch})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is pure datapath; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign level        = r_level;
  assign empty        = w_empty;
  assign full         = w_full;

endmodule
